// File: rtl/status_reg_if.sv
// Bus between the sequencer/ALU side and the processor status register.
// The master drives flag sources and update controls; the slave returns P views.
interface status_reg_if;
    logic       alu_n;
    logic       alu_z;
    logic       alu_v;
    logic       alu_c;
    logic       upd_en;
    logic [3:0] upd_mask;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic       load_en;
    logic [7:0] load_data;
    logic       irq_entry;
    logic       push_brk;
    logic       poll;
    logic [2:0] cond;
    logic [7:0] p;
    logic [7:0] p_push;
    logic       carry;
    logic       decimal;
    logic       branch_taken;
    logic       irq_mask;

    modport master (
        output alu_n, alu_z, alu_v, alu_c, upd_en, upd_mask, set_mask, clr_mask,
               load_en, load_data, irq_entry, push_brk, poll, cond,
        input  p, p_push, carry, decimal, branch_taken, irq_mask
    );

    modport slave (
        input  alu_n, alu_z, alu_v, alu_c, upd_en, upd_mask, set_mask, clr_mask,
               load_en, load_data, irq_entry, push_brk, poll, cond,
        output p, p_push, carry, decimal, branch_taken, irq_mask
    );
endinterface

// File: rtl/status_reg.sv
// Processor status register P: masked ALU flag capture, explicit set/clear,
// PLP/RTI load, interrupt entry, branch evaluation and the polled IRQ mask.
module status_reg #(
    parameter logic [7:0] RESET_P      = 8'h24,
    parameter bit         CMOS_IRQ_CLD = 1'b0
) (
    input logic        clk,
    input logic        rst,
    status_reg_if.slave bus
);

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
    logic irq_mask_q;
    logic [7:0] p_cur;
    logic taken;
    logic unused_bits;

    always_comb begin
        n_nx = n_q;
        v_nx = v_q;
        d_nx = d_q;
        i_nx = i_q;
        z_nx = z_q;
        c_nx = c_q;
        if (bus.load_en) begin
            n_nx = bus.load_data[7];
            v_nx = bus.load_data[6];
            d_nx = bus.load_data[3];
            i_nx = bus.load_data[2];
            z_nx = bus.load_data[1];
            c_nx = bus.load_data[0];
        end else begin
            if (bus.upd_en && bus.upd_mask[3]) n_nx = bus.alu_n;
            if (bus.upd_en && bus.upd_mask[2]) v_nx = bus.alu_v;
            if (bus.upd_en && bus.upd_mask[1]) z_nx = bus.alu_z;
            if (bus.upd_en && bus.upd_mask[0]) c_nx = bus.alu_c;
            // Clear then set, so a bit named in both masks ends up 1.
            n_nx = (n_nx & ~bus.clr_mask[7]) | bus.set_mask[7];
            v_nx = (v_nx & ~bus.clr_mask[6]) | bus.set_mask[6];
            d_nx = (d_nx & ~bus.clr_mask[3]) | bus.set_mask[3];
            i_nx = (i_nx & ~bus.clr_mask[2]) | bus.set_mask[2];
            z_nx = (z_nx & ~bus.clr_mask[1]) | bus.set_mask[1];
            c_nx = (c_nx & ~bus.clr_mask[0]) | bus.set_mask[0];
        end
        if (bus.irq_entry) begin
            i_nx = 1'b1;
            if (CMOS_IRQ_CLD) d_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= RESET_P[7];
            v_q        <= RESET_P[6];
            d_q        <= RESET_P[3];
            i_q        <= RESET_P[2];
            z_q        <= RESET_P[1];
            c_q        <= RESET_P[0];
            irq_mask_q <= RESET_P[2];
        end else begin
            n_q <= n_nx;
            v_q <= v_nx;
            d_q <= d_nx;
            i_q <= i_nx;
            z_q <= z_nx;
            c_q <= c_nx;
            // Mask samples I from before this edge: CLI/SEI/PLP act one poll late.
            if (bus.poll) irq_mask_q <= i_q;
        end
    end

    assign p_cur = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};

    always_comb begin
        case (bus.cond[2:1])
            2'b00:   taken = (n_q == bus.cond[0]);
            2'b01:   taken = (v_q == bus.cond[0]);
            2'b10:   taken = (c_q == bus.cond[0]);
            default: taken = (z_q == bus.cond[0]);
        endcase
    end

    assign bus.p            = p_cur;
    assign bus.p_push       = {p_cur[7:5], bus.push_brk, p_cur[3:0]};
    assign bus.carry        = c_q;
    assign bus.decimal      = d_q;
    assign bus.branch_taken = taken;
    assign bus.irq_mask     = irq_mask_q;

    // Bits 5 and 4 of the byte-wide inputs have no stored counterpart.
    assign unused_bits = ^{bus.load_data[5:4], bus.set_mask[5:4], bus.clr_mask[5:4]};

endmodule
